// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline.
//
// This module drives the enable and flush controls of the PC and of the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three
// kinds of hazard:
//   - taken-branch and jump squashes,
//   - load-use stalls,
//   - variable-latency data-memory accesses, handled by a two-state FSM
//     (RUN / MEM_WAIT) with a timeout counter.
// It also keeps saturating stall and flush statistics for debug readout.
//
// Parameters:
//   WAIT_TIMEOUT  maximum number of MEM_WAIT cycles before the access is
//                 aborted (legal range 1..65535)
//   CNT_W         width of the statistics counters
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ID_Rs, ID_Rt,         source fields of the ID-stage instruction,
//   ID_UsesRt             and whether rt is actually read
//   ID_Jump               jump decoded in ID
//   EX_MemRead, EX_Addr   EX-stage load flag and destination register
//   EX_BranchTaken        branch resolved taken in EX
//   MEM_MemRead,          MEM-stage load / store
//   MEM_MemWrite
//   mem_ready             data memory completes the access this cycle
//   PC_write ...          register enables and flushes
//     MEM_WB_flush        (combinational from state and current inputs)
//   mem_req               data-memory access request
//   mem_err               sticky timeout flag
//   stall_cnt, flush_cnt  saturating statistics counters
module pipe_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Addr,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_flush,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]      WAIT_LIMIT = 16'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic        access;
    logic        released;
    logic        timed_out;
    logic        frozen;
    logic        load_use;

    // Decode the access, release, freeze and load-use conditions.
    always_comb begin
        access = MEM_MemRead | MEM_MemWrite;
        // A release happens on completion, or once the wait budget is used up.
        released  = (state == ST_MEM_WAIT) && (mem_ready || (wait_cnt == WAIT_LIMIT));
        // Only an expiry without completion counts as an error.
        timed_out = (state == ST_MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LIMIT);
        if (state == ST_RUN) begin
            // The entry cycle into MEM_WAIT already freezes the pipeline.
            frozen = access && !mem_ready;
        end else begin
            frozen = !released;
        end
        load_use = EX_MemRead && (EX_Addr != 5'd0) &&
                   ((EX_Addr == ID_Rs) || (ID_UsesRt && (EX_Addr == ID_Rt)));
    end

    // Next-state logic of the memory-wait FSM.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (access && !mem_ready) begin
                    state_next = ST_MEM_WAIT;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (released) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_MEM_WAIT;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Pipeline control outputs, with priority branch > load-use > jump.
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        MEM_WB_flush = 1'b0;
        mem_req      = access;
        if (reset) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            mem_req      = 1'b0;
        end else if (frozen) begin
            // Hold everything upstream; bubble MEM/WB until the data returns.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_flush = 1'b1;
        end else if (EX_BranchTaken) begin
            // The branch squashes the ID instruction, so any load-use is moot.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_flush = 1'b1;
        end else begin
            PC_write = 1'b1;
        end
    end

    // State register, wait counter, sticky error flag and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= 16'd0;
            mem_err   <= 1'b0;
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            state <= state_next;
            // The counter only runs while staying in MEM_WAIT, so it is zero on entry.
            if ((state == ST_MEM_WAIT) && (state_next == ST_MEM_WAIT)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= 16'd0;
            end
            if (timed_out) begin
                mem_err <= 1'b1;
            end else begin
                mem_err <= mem_err;
            end
            if (!PC_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if ((IF_ID_flush || ID_EX_flush) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
//
// Two instances share the same stimulus:
//   u_a  default parameters (WAIT_TIMEOUT=255, CNT_W=16)
//   u_b  WAIT_TIMEOUT=4, CNT_W=4
//
// Each instance is checked every cycle against a behavioural model, and
// directed literal checks pin down the expected values at key points.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Addr;
    logic       ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken;
    logic       MEM_MemRead, MEM_MemWrite, mem_ready;

    logic pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, wbf_a, req_a, err_a;
    logic pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, wbf_b, req_b, err_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  armed  = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_TIMEOUT(255), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Addr(EX_Addr),
        .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .mem_ready(mem_ready),
        .PC_write(pcw_a), .IF_ID_write(ifw_a), .IF_ID_flush(iff_a),
        .ID_EX_write(idw_a), .ID_EX_flush(idf_a), .EX_MEM_write(exw_a),
        .MEM_WB_flush(wbf_a), .mem_req(req_a), .mem_err(err_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a));

    pipe_hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Addr(EX_Addr),
        .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .mem_ready(mem_ready),
        .PC_write(pcw_b), .IF_ID_write(ifw_b), .IF_ID_flush(iff_b),
        .ID_EX_write(idw_b), .ID_EX_flush(idf_b), .EX_MEM_write(exw_b),
        .MEM_WB_flush(wbf_b), .mem_req(req_b), .mem_err(err_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b));

    // ---------------- behavioural model ----------------
    typedef struct {
        bit in_wait;
        int waited;
        bit err;
        int stalls;
        int flushes;
    } mstate_t;

    typedef struct packed {
        logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, req;
    } mout_t;

    mstate_t ma, mb;

    function automatic mout_t model_out(mstate_t s, int wt);
        mout_t o;
        bit access, released, frozen, hazard;
        access   = MEM_MemRead || MEM_MemWrite;
        released = s.in_wait && (mem_ready || s.waited >= wt);
        frozen   = s.in_wait ? !released : (access && !mem_ready);
        hazard   = EX_MemRead && (EX_Addr != 5'd0) &&
                   ((EX_Addr == ID_Rs) || (ID_UsesRt && (EX_Addr == ID_Rt)));
        o = '0;
        if (reset) begin
            o = '0;
        end else if (frozen) begin
            o.memwb_f = 1'b1;
            o.req     = access;
        end else begin
            o.pc_w = 1'b1; o.ifid_w = 1'b1; o.idex_w = 1'b1; o.exmem_w = 1'b1;
            o.req  = access;
            if (EX_BranchTaken) begin
                o.ifid_f = 1'b1; o.idex_f = 1'b1;
            end else if (hazard) begin
                o.pc_w = 1'b0; o.ifid_w = 1'b0; o.idex_f = 1'b1;
            end else if (ID_Jump) begin
                o.ifid_f = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic mstate_t model_step(mstate_t s, int wt, int cmax);
        mout_t   o;
        mstate_t n;
        n = s;
        if (reset) begin
            n = '{default: 0};
            return n;
        end
        o = model_out(s, wt);
        if (!o.pc_w && n.stalls < cmax) n.stalls++;
        if ((o.ifid_f || o.idex_f) && n.flushes < cmax) n.flushes++;
        if (s.in_wait) begin
            if (mem_ready) begin
                n.in_wait = 1'b0;
            end else if (s.waited >= wt) begin
                n.in_wait = 1'b0;
                n.err     = 1'b1;
            end else begin
                n.waited++;
            end
        end else if ((MEM_MemRead || MEM_MemWrite) && !mem_ready) begin
            n.in_wait = 1'b1;
            n.waited  = 0;
        end
        return n;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model, then model advance.
    always @(negedge clk) begin
        if (armed) begin
            cmp("a_ctrl", 32'({pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, wbf_a, req_a}),
                32'(model_out(ma, 255)));
            cmp("a_mem_err", 32'(err_a), 32'(ma.err));
            cmp("a_stall_cnt", 32'(stall_a), 32'(ma.stalls));
            cmp("a_flush_cnt", 32'(flush_a), 32'(ma.flushes));
            cmp("b_ctrl", 32'({pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, wbf_b, req_b}),
                32'(model_out(mb, 4)));
            cmp("b_mem_err", 32'(err_b), 32'(mb.err));
            cmp("b_stall_cnt", 32'(stall_b), 32'(mb.stalls));
            cmp("b_flush_cnt", 32'(flush_b), 32'(mb.flushes));
        end
        ma = model_step(ma, 255, 65535);
        mb = model_step(mb, 4, 15);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
        EX_MemRead = 1'b0; EX_Addr = 5'd0; EX_BranchTaken = 1'b0;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ma = '{default: 0};
        mb = '{default: 0};
        // Reset: outputs forced low even with an access requested.
        step();
        MEM_MemRead = 1'b1;
        #1;
        cmp("rst_pc_write", 32'(pcw_a), 32'd0);
        cmp("rst_mem_req", 32'(req_a), 32'd0);
        step();
        reset = 1'b0;
        idle();
        armed = 1'b1;
        #1;
        cmp("post_rst_stall", 32'(stall_a), 32'd0);
        cmp("post_rst_err", 32'(err_a), 32'd0);

        // Load-use on rs: one-cycle stall.
        EX_MemRead = 1'b1; EX_Addr = 5'd8; ID_Rs = 5'd8;
        #1;
        cmp("lu_pc_write", 32'(pcw_a), 32'd0);
        cmp("lu_ifid_write", 32'(ifw_a), 32'd0);
        cmp("lu_idex_flush", 32'(idf_a), 32'd1);
        step();
        idle();
        #1;
        cmp("lu_after_pc", 32'(pcw_a), 32'd1);
        cmp("lu_stall_cnt", 32'(stall_a), 32'd1);
        cmp("lu_flush_cnt", 32'(flush_a), 32'd1);

        // EX_Addr = 0 never stalls.
        EX_MemRead = 1'b1; EX_Addr = 5'd0; ID_Rs = 5'd0;
        #1;
        cmp("r0_pc_write", 32'(pcw_a), 32'd1);
        step();
        // rt hazard only counts when rt is used.
        EX_Addr = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 1'b1;
        step();
        ID_UsesRt = 1'b0;
        step();

        // Branch beats load-use and jump.
        EX_MemRead = 1'b1; EX_Addr = 5'd9; ID_Rs = 5'd9; ID_Jump = 1'b1; EX_BranchTaken = 1'b1;
        #1;
        cmp("br_ifid_flush", 32'(iff_a), 32'd1);
        cmp("br_idex_flush", 32'(idf_a), 32'd1);
        cmp("br_pc_write", 32'(pcw_a), 32'd1);
        step();
        idle();
        ID_Jump = 1'b1;
        #1;
        cmp("jmp_flags", 32'({iff_a, idf_a}), 32'b10);
        step();

        // Memory wait: three freeze cycles, then release.
        do_reset();
        MEM_MemRead = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp("mw_freeze", 32'({pcw_a, ifw_a, idw_a, exw_a, wbf_a}), 32'b00001);
            step();
        end
        mem_ready = 1'b1;
        #1;
        cmp("mw_release", 32'({pcw_a, ifw_a, idw_a, exw_a, wbf_a}), 32'b11110);
        step();
        idle();
        #1;
        cmp("mw_stall_cnt", 32'(stall_a), 32'd3);

        // Back-to-back access; hazards held during freeze, resolved on release.
        MEM_MemWrite = 1'b1;
        step();
        EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Addr = 5'd4; ID_Rs = 5'd4;
        step();
        step();
        mem_ready = 1'b1;
        step();
        idle();
        MEM_MemRead = 1'b1;
        step();
        mem_ready = 1'b1;
        step();
        idle();
        step();

        // Timeout on u_b (WAIT_TIMEOUT=4).
        do_reset();
        MEM_MemWrite = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            cmp("to_freeze_b", 32'(pcw_b), 32'd0);
            step();
        end
        #1;
        cmp("to_release_b", 32'(pcw_b), 32'd1);
        cmp("to_err_not_yet", 32'(err_b), 32'd0);
        step();
        MEM_MemWrite = 1'b0;
        #1;
        cmp("to_err_set", 32'(err_b), 32'd1);
        cmp("to_a_still_frozen", 32'(pcw_a), 32'd0);
        step();
        step();
        step();
        #1;
        cmp("to_err_sticky", 32'(err_b), 32'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        cmp("to_a_no_err", 32'(err_a), 32'd0);

        // Reset asserted on the 2nd MEM_WAIT cycle.
        MEM_MemRead = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        cmp("rmw_forced", 32'({pcw_b, ifw_b, idw_b, exw_b, iff_b, idf_b, wbf_b, req_b}), 32'd0);
        step();
        reset = 1'b0;
        MEM_MemRead = 1'b0;
        #1;
        cmp("rmw_stall", 32'(stall_b), 32'd0);
        cmp("rmw_err", 32'(err_b), 32'd0);
        cmp("rmw_run", 32'(pcw_b), 32'd1);

        // Saturation: 20 consecutive load-use stalls.
        EX_MemRead = 1'b1; EX_Addr = 5'd7; ID_Rs = 5'd7;
        for (int k = 0; k < 20; k++) step();
        idle();
        #1;
        cmp("sat_stall_b", 32'(stall_b), 32'd15);
        cmp("sat_flush_b", 32'(flush_b), 32'd15);
        cmp("sat_stall_a", 32'(stall_a), 32'd20);
        EX_MemRead = 1'b1; EX_Addr = 5'd7; ID_Rs = 5'd7;
        step();
        step();
        idle();
        #1;
        cmp("sat_hold_b", 32'(stall_b), 32'd15);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
